// File: rtl/gmii_rx_frame_if.sv
// GMII receive pins together with the deframed byte stream and frame statistics.
`timescale 1ns/1ps
interface gmii_rx_frame_if;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic [2:0]  rx_err_code;
    logic [15:0] rx_len;
    logic [15:0] frame_good_cnt;
    logic [15:0] frame_bad_cnt;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_err_code, rx_len,
        input  frame_good_cnt, frame_bad_cnt
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_err_code, rx_len,
        output frame_good_cnt, frame_bad_cnt
    );
endinterface

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, forwards frame bytes with sof/eof,
// checks FCS, length and rx_er, and counts good/bad frames.
`timescale 1ns/1ps
module gmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic           gmii_rx_clk,
    input  logic           rst,
    gmii_rx_frame_if.slave bus
);
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state_q, state_d;

    logic [7:0]  rxd_p0;
    logic        dv_p0;
    logic        er_p0;

    logic [7:0]  hold_p1;
    logic        vld_p1;
    logic [31:0] crc_q;
    logic [15:0] len_q;
    logic        er_seen_q;
    logic        sof_pend_q;

    logic [7:0]  rx_data_q;
    logic        rx_valid_q, rx_sof_q, rx_eof_q, rx_err_q;
    logic [2:0]  rx_err_code_q;
    logic [15:0] rx_len_q;
    logic [15:0] good_cnt_q, bad_cnt_q;

    logic        start_frame, take_byte, end_frame, over_len;
    logic        emit_mid, emit_last, emit_any;
    logic        cnt_good, cnt_bad;
    logic [2:0]  frame_code;

    // Register orientation is the bit-reverse of the textbook reflected CRC,
    // which lets data be consumed LSB first while shifting left.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [2:0] err_code(input logic len_bad, input logic er_seen,
                                            input logic [31:0] crc);
        return {len_bad, er_seen, (crc != CRC_RESIDUE)};
    endfunction

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        take_byte   = 1'b0;
        end_frame   = 1'b0;
        over_len    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dv_p0) state_d = (rxd_p0 == PRE_BYTE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!dv_p0) begin
                    state_d = IDLE;
                end else if (rxd_p0 == SFD_BYTE) begin
                    state_d     = DATA;
                    start_frame = 1'b1;
                end else if (rxd_p0 != PRE_BYTE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!dv_p0) begin
                    end_frame = 1'b1;
                    state_d   = IDLE;
                end else if (len_q == MAX_LEN_W) begin
                    over_len = 1'b1;
                    state_d  = DROP;
                end else begin
                    take_byte = 1'b1;
                end
            end
            DROP: begin
                if (!dv_p0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // An overlength frame always has a byte in hold, since MAX_LEN bytes were taken.
    assign emit_mid   = take_byte & vld_p1;
    assign emit_last  = (end_frame & vld_p1) | over_len;
    assign emit_any   = emit_mid | emit_last;
    assign frame_code = err_code(over_len | (len_q < MIN_LEN_W), er_seen_q, crc_q);
    assign cnt_good   = end_frame & vld_p1 & (frame_code == 3'b000);
    assign cnt_bad    = over_len | (end_frame & ~cnt_good);

    // ---- stage p0: input register; stage p1: hold register ----
    always_ff @(posedge gmii_rx_clk) begin
        rxd_p0 <= bus.gmii_rxd;
        if (take_byte) hold_p1 <= rxd_p0;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            dv_p0         <= 1'b0;
            er_p0         <= 1'b0;
            vld_p1        <= 1'b0;
            crc_q         <= CRC_INIT;
            len_q         <= 16'd0;
            er_seen_q     <= 1'b0;
            sof_pend_q    <= 1'b0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            rx_sof_q      <= 1'b0;
            rx_eof_q      <= 1'b0;
            rx_err_q      <= 1'b0;
            rx_err_code_q <= 3'b000;
            rx_len_q      <= 16'd0;
            good_cnt_q    <= 16'd0;
            bad_cnt_q     <= 16'd0;
        end else begin
            dv_p0      <= bus.gmii_rx_dv;
            er_p0      <= bus.gmii_rx_er;
            rx_valid_q <= emit_any;
            rx_sof_q   <= emit_any & sof_pend_q;
            rx_eof_q   <= emit_last;

            if (start_frame) begin
                crc_q      <= CRC_INIT;
                len_q      <= 16'd0;
                er_seen_q  <= 1'b0;
                vld_p1     <= 1'b0;
                sof_pend_q <= 1'b1;
            end

            if (take_byte) begin
                crc_q     <= crc32_byte(crc_q, rxd_p0);
                len_q     <= len_q + 16'd1;
                er_seen_q <= er_seen_q | er_p0;
                vld_p1    <= 1'b1;
            end

            // ---- stage p2: output registers ----
            if (emit_any) begin
                rx_data_q  <= hold_p1;
                sof_pend_q <= 1'b0;
            end

            if (emit_last) begin
                rx_err_code_q <= frame_code;
                rx_err_q      <= |frame_code;
                rx_len_q      <= len_q;
                vld_p1        <= 1'b0;
            end

            if (cnt_good) good_cnt_q <= good_cnt_q + 16'd1;
            if (cnt_bad)  bad_cnt_q  <= bad_cnt_q + 16'd1;
        end
    end

    assign bus.rx_data        = rx_data_q;
    assign bus.rx_valid       = rx_valid_q;
    assign bus.rx_sof         = rx_sof_q;
    assign bus.rx_eof         = rx_eof_q;
    assign bus.rx_err         = rx_err_q;
    assign bus.rx_err_code    = rx_err_code_q;
    assign bus.rx_len         = rx_len_q;
    assign bus.frame_good_cnt = good_cnt_q;
    assign bus.frame_bad_cnt  = bad_cnt_q;
endmodule

// File: doc/gmii_rx_frame.md
# gmii_rx_frame

Receive-side GMII framer for the Ethernet datapath. Takes the 8-bit GMII receive bus, produced by the RGMII DDR input stage in the `gmii_rx_clk` domain, and locates preamble/SFD. It strips them and forwards frame bytes (destination MAC through FCS) as a byte stream with start/end markers. It checks FCS (CRC-32), length and `gmii_rx_er`, and keeps good/bad frame counters.

## Interface
- `MIN_LEN`, default 64: minimum legal frame length in bytes, FCS included.
- `MAX_LEN`, default 1518: maximum legal frame length in bytes, FCS included; must be ≤ 65535.
- `gmii_rx_clk` input 1: receive clock, the only clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `gmii_rxd` input 8: GMII receive data.
- `gmii_rx_dv` input 1: GMII receive data valid.
- `gmii_rx_er` input 1: GMII receive error. Ignored while `gmii_rx_dv`=0.
- `rx_data` output 8: frame byte.
- `rx_valid` output 1: `rx_data` valid this cycle.
- `rx_sof` output 1: first byte of frame. Qualified by `rx_valid`.
- `rx_eof` output 1: last byte of frame. Qualified by `rx_valid`.
- `rx_err` output 1: frame bad. Valid only with `rx_eof`. Equals the OR of the `rx_err_code` bits.
- `rx_err_code` output 3: valid with `rx_eof`. Bit 0 = FCS mismatch, bit 1 = `gmii_rx_er` seen, bit 2 = length violation.
- `rx_len` output 16: byte count of the frame, FCS included. Valid with `rx_eof`.
- `frame_good_cnt` output 16: count of frames ended with `rx_err`=0. Wraps 0xFFFF→0.
- `frame_bad_cnt` output 16: count of bad or discarded frames. Wraps 0xFFFF→0.

## Operation
- Input stage: `gmii_rxd`, `gmii_rx_dv` and `gmii_rx_er` are registered once (stage S1). The FSM acts only on S1 values.
- FSM states are IDLE, PREAMBLE, DATA and DROP.
- IDLE:
  - dv=1 and byte=0x55 → PREAMBLE.
  - dv=1 and any other byte → DROP. No counter change.
- PREAMBLE:
  - 0x55 → stay.
  - 0xD5 → DATA. Clear CRC to 0xFFFFFFFF, clear the length counter, clear the error flags.
  - Any other byte → DROP.
  - dv=0 → IDLE.
  - No output and no counter change in any of these cases.
- DATA, byte with dv=1:
  - Load the byte into the hold register and update CRC-32 (poly 0x04C11DB7, reflected, LSB first).
  - Increment the length counter.
  - OR `gmii_rx_er` into error bit 1.
  - On the same edge, if the hold register was already full, emit its previous content: `rx_valid`=1, and `rx_sof`=1 only for the first emitted byte.
- DATA, dv falls (S1 dv=0):
  - If the hold register is full, emit it with `rx_eof`=1.
  - FCS is good iff the CRC register equals the residue 0xC704DD7B.
  - Bit 2 is set if `rx_len` < `MIN_LEN`.
  - Increment exactly one counter.
  - → IDLE.
- SFD followed immediately by dv=0 (zero data bytes): no output, `frame_bad_cnt`+1, → IDLE.
- Overlength: when byte `MAX_LEN`+1 arrives, emit the held byte (byte `MAX_LEN`) with `rx_eof`=1 and `rx_len`=`MAX_LEN`.
  - Set bit 2, plus bit 0/bit 1 as computed so far.
  - `frame_bad_cnt`+1, → DROP.
- DROP: discard everything until dv=0, then → IDLE.
- Frame bytes are passed through unmodified, FCS bytes included.

## Timing
- Reset values:
  - All outputs are 0, including `rx_data`, both counters and `rx_err_code`.
  - FSM is in IDLE, the hold register is empty, CRC is 0xFFFFFFFF.
- Output pulses (`rx_valid`, `rx_sof`, `rx_eof`) are single-cycle, registered.
- `rx_data`, `rx_err_code` and `rx_len` are registered and hold their value between pulses.
- Fixed latency: a byte sampled from the pins at edge t is output at edge t+2.
  - This holds for every byte, including the last, because the dv fall is seen in S1 at edge t+1.
- `rx_valid` is contiguous for back-to-back bytes. There are no gaps within a frame.
- Counters update on the same edge as `rx_eof`, or as the zero-byte discard.
- Minimum inter-frame gap is 1 idle cycle. The next frame's preamble is accepted on the cycle after returning to IDLE.
- Reset mid-frame: all outputs clear on the next edge. No `rx_eof` is generated for the aborted frame. If dv is still high, the in-progress frame's data lands in IDLE and goes to DROP, unless the byte happens to be 0x55.

## Test plan
- 64-byte frame (7×0x55, 0xD5, 60 payload bytes, correct FCS) → 64 `rx_valid` cycles:
  - `rx_sof` on byte 1 and `rx_eof` on byte 64.
  - `rx_len`=64, `rx_err_code`=000.
  - `frame_good_cnt`=1.
  - First `rx_valid` appears 2 edges after the first DA byte is on the pins.
- Same frame with payload byte 20 XORed with 0x01 → `rx_eof` with `rx_err_code`=001 and `frame_bad_cnt`=1.
- Same frame with `gmii_rx_er`=1 for one data cycle → `rx_err_code`=010. `gmii_rx_er`=1 with dv=0 between frames → no effect.
- 60-byte frame with valid FCS → `rx_len`=60 and `rx_err_code`=100. 1519-byte frame:
  - `rx_eof` on byte 1518 with bit 2 set and `rx_len`=1518.
  - No further `rx_valid` for that frame.
  - A following good frame gives `frame_good_cnt`+1.
- Preamble `0x55 0x55 0x13 ...` → no output and no counter change. SFD then dv=0 → no output and `frame_bad_cnt`+1.
- `rst`=1 for one cycle at data byte 30 of a good frame → outputs and counters are 0 next edge and no `rx_eof` is emitted. A following good frame is received with `frame_good_cnt`=1.
